// File: rtl/host_cmd_handler.sv
// host_cmd_handler: client side of the host command channel.
// Decodes each latched command word, drives the core reset, the data-slot
// request handshake and the all-complete pulse, then reports result/response
// with a single-cycle done pulse. A command is not re-accepted until the
// bridge drops cmd_valid, so one command can never complete twice.
module host_cmd_handler #(
  parameter int          RESET_MIN_CYCLES = 16,
  parameter logic [31:0] SLOT_TIMEOUT     = 32'd1_000_000,
  parameter logic [15:0] CORE_STATUS_RUN  = 16'h0004,
  parameter logic [15:0] CORE_STATUS_RST  = 16'h0001
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  input  logic [15:0]  cmd_word,
  input  logic [127:0] cmd_param,
  output logic [15:0]  cmd_progress,
  output logic         cmd_done,
  output logic [15:0]  cmd_result,
  output logic [31:0]  cmd_response,
  output logic         core_reset_n,
  output logic         slot_req_valid,
  output logic         slot_req_write,
  output logic [15:0]  slot_req_id,
  output logic [31:0]  slot_req_offset,
  output logic [31:0]  slot_req_length,
  input  logic         slot_ack,
  input  logic [15:0]  slot_ack_code,
  output logic         slot_all_complete
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_EXEC      = 3'd1;
  localparam logic [2:0] S_SLOT_WAIT = 3'd2;
  localparam logic [2:0] S_DONE      = 3'd3;
  localparam logic [2:0] S_RELEASE   = 3'd4;

  localparam logic [15:0] RST_MIN = 16'(RESET_MIN_CYCLES);

  localparam logic [15:0] CMD_STATUS     = 16'h0000;
  localparam logic [15:0] CMD_RESET_IN   = 16'h0010;
  localparam logic [15:0] CMD_RESET_OUT  = 16'h0011;
  localparam logic [15:0] CMD_SLOT_READ  = 16'h0080;
  localparam logic [15:0] CMD_SLOT_WRITE = 16'h0082;
  localparam logic [15:0] CMD_ALL_DONE   = 16'h008F;

  logic [2:0]   state;
  logic [15:0]  word_q;
  logic [127:0] param_q;
  logic [15:0]  rst_cnt;
  logic [31:0]  tmo_cnt;
  logic [31:0]  tmo_next;
  logic         reset_enter;

  assign reset_enter = (state == S_EXEC) && (word_q == CMD_RESET_IN);
  assign tmo_next    = tmo_cnt + 32'd1;
  assign cmd_done    = (state == S_DONE);

  // Count how long the core has been held in reset, saturating at the minimum hold time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_cnt <= 16'd0;
    end else if (reset_enter) begin
      rst_cnt <= 16'd0;
    end else if (!core_reset_n && (rst_cnt < RST_MIN)) begin
      rst_cnt <= rst_cnt + 16'd1;
    end
  end

  // Command sequencer: latch, decode/act, wait for the slot handshake, report, then wait for release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      word_q            <= 16'd0;
      param_q           <= 128'd0;
      tmo_cnt           <= 32'd0;
      cmd_progress      <= 16'd0;
      cmd_result        <= 16'd0;
      cmd_response      <= 32'd0;
      core_reset_n      <= 1'b0;
      slot_req_valid    <= 1'b0;
      slot_req_write    <= 1'b0;
      slot_req_id       <= 16'd0;
      slot_req_offset   <= 32'd0;
      slot_req_length   <= 32'd0;
      slot_all_complete <= 1'b0;
    end else begin
      slot_all_complete <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            word_q  <= cmd_word;
            param_q <= cmd_param;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (word_q)
            CMD_STATUS: begin
              cmd_result   <= core_reset_n ? CORE_STATUS_RUN : CORE_STATUS_RST;
              cmd_response <= 32'd0;
              state        <= S_DONE;
            end
            CMD_RESET_IN: begin
              core_reset_n <= 1'b0;
              cmd_result   <= 16'd0;
              cmd_response <= 32'd0;
              state        <= S_DONE;
            end
            CMD_RESET_OUT: begin
              if (core_reset_n) begin
                cmd_result   <= 16'd0;
                cmd_response <= 32'd0;
                state        <= S_DONE;
              end else if (rst_cnt == RST_MIN) begin
                core_reset_n <= 1'b1;
                cmd_progress <= 16'd0;
                cmd_result   <= 16'd0;
                cmd_response <= 32'd0;
                state        <= S_DONE;
              end else begin
                cmd_progress <= RST_MIN - rst_cnt;
              end
            end
            CMD_SLOT_READ, CMD_SLOT_WRITE: begin
              slot_req_write  <= word_q[1];
              slot_req_id     <= param_q[111:96];
              slot_req_offset <= param_q[95:64];
              slot_req_length <= param_q[63:32];
              slot_req_valid  <= 1'b1;
              tmo_cnt         <= 32'd0;
              cmd_progress    <= 16'd0;
              state           <= S_SLOT_WAIT;
            end
            CMD_ALL_DONE: begin
              slot_all_complete <= 1'b1;
              cmd_result        <= 16'd0;
              cmd_response      <= 32'd0;
              state             <= S_DONE;
            end
            default: begin
              cmd_result   <= 16'h0001;
              cmd_response <= 32'd0;
              state        <= S_DONE;
            end
          endcase
        end
        S_SLOT_WAIT: begin
          if (slot_ack) begin
            slot_req_valid <= 1'b0;
            cmd_result     <= slot_ack_code;
            cmd_response   <= 32'd0;
            state          <= S_DONE;
          end else if (tmo_cnt == SLOT_TIMEOUT - 32'd1) begin
            slot_req_valid <= 1'b0;
            cmd_result     <= 16'hFFFF;
            cmd_response   <= 32'd0;
            state          <= S_DONE;
          end else begin
            tmo_cnt      <= tmo_next;
            cmd_progress <= tmo_next[15:0];
          end
        end
        S_DONE: begin
          state <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!cmd_valid) begin
            cmd_progress <= 16'd0;
            state        <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_cmd_handler.sv
// tb_host_cmd_handler: directed, table-driven bench for host_cmd_handler.
`timescale 1ns/1ps
module tb_host_cmd_handler;

  localparam logic [31:0] TMO = 32'd64;

  logic         clk;
  logic         reset_n;
  logic         cmd_valid;
  logic [15:0]  cmd_word;
  logic [127:0] cmd_param;
  logic [15:0]  cmd_progress;
  logic         cmd_done;
  logic [15:0]  cmd_result;
  logic [31:0]  cmd_response;
  logic         core_reset_n;
  logic         slot_req_valid;
  logic         slot_req_write;
  logic [15:0]  slot_req_id;
  logic [31:0]  slot_req_offset;
  logic [31:0]  slot_req_length;
  logic         slot_ack;
  logic [15:0]  slot_ack_code;
  logic         slot_all_complete;

  int checks;
  int failures;

  host_cmd_handler #(
    .RESET_MIN_CYCLES(16),
    .SLOT_TIMEOUT(TMO),
    .CORE_STATUS_RUN(16'h0004),
    .CORE_STATUS_RST(16'h0001)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_word(cmd_word),
    .cmd_param(cmd_param),
    .cmd_progress(cmd_progress),
    .cmd_done(cmd_done),
    .cmd_result(cmd_result),
    .cmd_response(cmd_response),
    .core_reset_n(core_reset_n),
    .slot_req_valid(slot_req_valid),
    .slot_req_write(slot_req_write),
    .slot_req_id(slot_req_id),
    .slot_req_offset(slot_req_offset),
    .slot_req_length(slot_req_length),
    .slot_ack(slot_ack),
    .slot_ack_code(slot_ack_code),
    .slot_all_complete(slot_all_complete)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [15:0]  word;
    logic [127:0] param;
    logic [15:0]  exp_result;
    logic         exp_core;
    int           exp_ac;
  } vec_t;

  vec_t vecs[6];

  logic        cap_write;
  logic [15:0] cap_id;
  logic [31:0] cap_offset;
  logic [31:0] cap_length;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Hold valid three extra cycles after done, then drop it; count any further done pulses.
  task automatic releaseCmd(output int extra_done);
    extra_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (cmd_done) extra_done++;
    end
    cmd_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (cmd_done) extra_done++;
    end
  endtask

  // Issue one command; optionally acknowledge the slot request on its ack_at-th visible cycle.
  task automatic applyStimulus(input logic [15:0] w, input logic [127:0] p,
                               input int ack_at, input logic [15:0] code,
                               output int lat, output int vcount, output int ac,
                               output int got, output int extra_done);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_word  = w;
    cmd_param = p;
    lat = 0; vcount = 0; ac = 0; got = 0;
    for (int i = 0; i < 500 && got == 0; i++) begin
      @(negedge clk);
      slot_ack = 1'b0;
      lat++;
      if (slot_all_complete) ac++;
      if (slot_req_valid) begin
        vcount++;
        if (vcount == 1) begin
          cap_write  = slot_req_write;
          cap_id     = slot_req_id;
          cap_offset = slot_req_offset;
          cap_length = slot_req_length;
        end
        if (vcount == ack_at) begin
          slot_ack      = 1'b1;
          slot_ack_code = code;
        end
      end
      if (cmd_done) got = 1;
    end
    slot_ack = 1'b0;
    if (got == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout cmd=0x%0h actual=no_done expected=done", w);
    end
    releaseCmd(extra_done);
  endtask

  initial begin
    int lat, vcount, ac, got, extra, first_prog, prev_prog, bad_step;

    checks = 0; failures = 0;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_word = 16'd0; cmd_param = 128'd0;
    slot_ack = 1'b0; slot_ack_code = 16'd0;

    vecs[0] = '{16'h0000, 128'd0, 16'h0004, 1'b1, 0};
    vecs[1] = '{16'h1234, 128'd0, 16'h0001, 1'b1, 0};
    vecs[2] = '{16'h008F, 128'd0, 16'h0000, 1'b1, 1};
    vecs[3] = '{16'h0011, 128'd0, 16'h0000, 1'b1, 0};
    vecs[4] = '{16'h0010, 128'd0, 16'h0000, 1'b0, 0};
    vecs[5] = '{16'h0000, 128'd0, 16'h0001, 1'b0, 0};

    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    checkOutput("rst_done", 32'(cmd_done), 32'd0);
    checkOutput("rst_result", 32'(cmd_result), 32'd0);
    checkOutput("rst_progress", 32'(cmd_progress), 32'd0);
    checkOutput("rst_core_reset_n", 32'(core_reset_n), 32'd0);
    checkOutput("rst_slot_valid", 32'(slot_req_valid), 32'd0);
    reset_n = 1'b1;

    $display("[TB] reset exit issued 5 cycles after release");
    repeat (4) @(negedge clk);
    cmd_valid = 1'b1; cmd_word = 16'h0011; cmd_param = 128'd0;
    lat = 0; got = 0; first_prog = 0; prev_prog = 0; bad_step = 0;
    for (int i = 0; i < 100 && got == 0; i++) begin
      @(negedge clk);
      lat++;
      if (cmd_progress != 16'd0) begin
        if (first_prog == 0) first_prog = int'(cmd_progress);
        else if (int'(cmd_progress) != prev_prog - 1) bad_step++;
        prev_prog = int'(cmd_progress);
      end
      if (cmd_done) got = 1;
    end
    checkOutput("exit_done_seen", 32'(got), 32'd1);
    checkOutput("exit_first_progress", 32'(first_prog), 32'd11);
    checkOutput("exit_last_progress", 32'(prev_prog), 32'd1);
    checkOutput("exit_progress_steps", 32'(bad_step), 32'd0);
    checkOutput("exit_latency", 32'(lat), 32'd13);
    checkOutput("exit_result", 32'(cmd_result), 32'd0);
    checkOutput("exit_core_reset_n", 32'(core_reset_n), 32'd1);
    releaseCmd(extra);
    checkOutput("exit_no_second_done", 32'(extra), 32'd0);

    $display("[TB] table of single-cycle commands");
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].word, vecs[v].param, 0, 16'd0, lat, vcount, ac, got, extra);
      checkOutput($sformatf("vec%0d_latency", v), 32'(lat), 32'd2);
      checkOutput($sformatf("vec%0d_result", v), 32'(cmd_result), 32'(vecs[v].exp_result));
      checkOutput($sformatf("vec%0d_response", v), cmd_response, 32'd0);
      checkOutput($sformatf("vec%0d_core_reset_n", v), 32'(core_reset_n), 32'(vecs[v].exp_core));
      checkOutput($sformatf("vec%0d_all_complete", v), 32'(ac), 32'(vecs[v].exp_ac));
      checkOutput($sformatf("vec%0d_no_second_done", v), 32'(extra), 32'd0);
    end

    $display("[TB] slot write acked after 7 cycles");
    applyStimulus(16'h0082, {32'h0000_0003, 32'h0000_0100, 32'h0000_0200, 32'hDEAD_BEEF},
                  7, 16'h0000, lat, vcount, ac, got, extra);
    checkOutput("wr_req_write", 32'(cap_write), 32'd1);
    checkOutput("wr_req_id", 32'(cap_id), 32'd3);
    checkOutput("wr_req_offset", cap_offset, 32'h100);
    checkOutput("wr_req_length", cap_length, 32'h200);
    checkOutput("wr_latency", 32'(lat), 32'd9);
    checkOutput("wr_result", 32'(cmd_result), 32'h0000);
    checkOutput("wr_valid_dropped", 32'(slot_req_valid), 32'd0);
    checkOutput("wr_no_second_done", 32'(extra), 32'd0);

    $display("[TB] slot read with no ack");
    cmd_result_preload();
    applyStimulus(16'h0080, {32'h0000_0007, 32'h0000_0040, 32'h0000_0010, 32'd0},
                  0, 16'h0000, lat, vcount, ac, got, extra);
    checkOutput("tmo_req_write", 32'(cap_write), 32'd0);
    checkOutput("tmo_req_id", 32'(cap_id), 32'd7);
    checkOutput("tmo_valid_cycles", 32'(vcount), TMO);
    checkOutput("tmo_latency", 32'(lat), TMO + 32'd2);
    checkOutput("tmo_result", 32'(cmd_result), 32'hFFFF);
    checkOutput("tmo_valid_dropped", 32'(slot_req_valid), 32'd0);

    $display("[TB] slot read acked on the timeout cycle");
    applyStimulus(16'h0080, {32'h0000_0001, 32'd0, 32'd4, 32'd0},
                  int'(TMO), 16'h5A5A, lat, vcount, ac, got, extra);
    checkOutput("ackwin_latency", 32'(lat), TMO + 32'd2);
    checkOutput("ackwin_result", 32'(cmd_result), 32'h5A5A);

    $display("[TB] async reset during slot wait");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_word = 16'h0082; cmd_param = {32'd2, 32'd0, 32'd8, 32'd0};
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      if (slot_req_valid) got = 1;
    end
    checkOutput("areset_req_seen", 32'(got), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("areset_slot_valid", 32'(slot_req_valid), 32'd0);
    checkOutput("areset_done", 32'(cmd_done), 32'd0);
    checkOutput("areset_core_reset_n", 32'(core_reset_n), 32'd0);
    checkOutput("areset_result", 32'(cmd_result), 32'd0);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(16'h0000, 128'd0, 0, 16'd0, lat, vcount, ac, got, extra);
    checkOutput("post_reset_latency", 32'(lat), 32'd2);
    checkOutput("post_reset_result", 32'(cmd_result), 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Leaves result at a known non-FFFF value so the timeout result is a real change.
  task automatic cmd_result_preload();
    int lat, vcount, ac, got, extra;
    applyStimulus(16'h0000, 128'd0, 0, 16'd0, lat, vcount, ac, got, extra);
    checkOutput("preload_result", 32'(cmd_result), 32'h0001);
  endtask

endmodule
